// File: rtl/fog_rate_decimator_if.sv
// Control, step-input and CPU-readout bundle of the FOG rate decimator.
// The master modport is the FOG loop / CPU side; the slave modport is the decimator itself.
interface fog_rate_decimator_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
);
  logic                     i_en;
  logic                     i_clr;
  logic                     i_trig;
  logic signed [DATA_W-1:0] i_step;
  logic [CNT_W-1:0]         i_dec_cnt;
  logic [4:0]               i_avg_shift;
  logic                     i_rd_ack;
  logic signed [ACC_W-1:0]  o_sum;
  logic signed [DATA_W-1:0] o_avg;
  logic                     o_valid;
  logic                     o_overrun;
  logic                     o_sat;
  logic [CNT_W-1:0]         o_frame_cnt;

  modport master (
    output i_en, i_clr, i_trig, i_step, i_dec_cnt, i_avg_shift, i_rd_ack,
    input  o_sum, o_avg, o_valid, o_overrun, o_sat, o_frame_cnt
  );

  modport slave (
    input  i_en, i_clr, i_trig, i_step, i_dec_cnt, i_avg_shift, i_rd_ack,
    output o_sum, o_avg, o_valid, o_overrun, o_sat, o_frame_cnt
  );
endinterface

// File: rtl/fog_rate_decimator.sv
// Integrates FOG feedback steps over a programmable number of triggers and
// hands each frame's saturated sum and scaled average to the CPU via valid/ack.
module fog_rate_decimator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fog_rate_decimator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // DATA_W signed limits, sign-extended to accumulator width for comparison.
  localparam logic signed [ACC_W-1:0] AVG_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AVG_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

  state_t                   state, state_d;
  logic signed [ACC_W-1:0]  acc, acc_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [CNT_W-1:0]         dec_reg, dec_d;
  logic [CNT_W-1:0]         dec_new;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     latch;
  logic                     sat_hit;

  logic signed [ACC_W-1:0]  step_ext;
  logic signed [ACC_W:0]    sum_wide;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  acc_sat;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] avg_sat;

  assign dec_new  = (bus.i_dec_cnt == '0) ? CNT_ONE : bus.i_dec_cnt;
  assign cnt_inc  = cnt + CNT_ONE;
  assign step_ext = {{(ACC_W-DATA_W){bus.i_step[DATA_W-1]}}, bus.i_step};

  // One guard bit: overflow shows as disagreement between the top two bits.
  assign sum_wide = {acc[ACC_W-1], acc} + {step_ext[ACC_W-1], step_ext};
  assign acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign acc_sat  = acc_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

  assign shifted  = acc >>> bus.i_avg_shift;

  always_comb begin
    if (shifted > AVG_MAX)      avg_sat = AVG_MAX[DATA_W-1:0];
    else if (shifted < AVG_MIN) avg_sat = AVG_MIN[DATA_W-1:0];
    else                        avg_sat = shifted[DATA_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      dec_reg <= CNT_ONE;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      dec_reg <= dec_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    dec_d   = dec_reg;
    latch   = 1'b0;
    sat_hit = 1'b0;

    if (bus.i_clr) begin
      // Clear wins over a frame completing in the same cycle.
      state_d = bus.i_en ? ST_ACC : ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      dec_d   = dec_new;
    end else begin
      unique case (state)
        ST_IDLE: begin
          acc_d = '0;
          cnt_d = '0;
          if (bus.i_en) begin
            state_d = ST_ACC;
            dec_d   = dec_new;
          end
        end

        ST_ACC: begin
          if (!bus.i_en) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else if (bus.i_trig) begin
            acc_d   = acc_sat;
            sat_hit = acc_ovf;
            cnt_d   = cnt_inc;
            if (cnt_inc == dec_reg) state_d = ST_DUMP;
          end
        end

        ST_DUMP: begin
          latch = 1'b1;
          dec_d = dec_new;
          if (bus.i_en && bus.i_trig) begin
            // A trigger during the dump opens the next frame; with one
            // trigger per frame that frame is already complete.
            acc_d   = step_ext;
            cnt_d   = CNT_ONE;
            state_d = (dec_new == CNT_ONE) ? ST_DUMP : ST_ACC;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = bus.i_en ? ST_ACC : ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_sum       <= '0;
      bus.o_avg       <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_overrun   <= 1'b0;
      bus.o_sat       <= 1'b0;
      bus.o_frame_cnt <= '0;
    end else if (bus.i_clr) begin
      // The last frame's data stays readable across a clear.
      bus.o_valid     <= 1'b0;
      bus.o_overrun   <= 1'b0;
      bus.o_sat       <= 1'b0;
      bus.o_frame_cnt <= '0;
    end else begin
      if (sat_hit) bus.o_sat <= 1'b1;
      if (latch) begin
        bus.o_sum       <= acc;
        bus.o_avg       <= avg_sat;
        bus.o_valid     <= 1'b1;
        bus.o_frame_cnt <= bus.o_frame_cnt + CNT_ONE;
        if (bus.o_valid && !bus.i_rd_ack) bus.o_overrun <= 1'b1;
      end else if (bus.i_rd_ack) begin
        bus.o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fog_rate_decimator.sv
// Self-checking bench for fog_rate_decimator: directed scenarios plus random
// traffic, compared each cycle against a frame-level queue model.
module tb_fog_rate_decimator;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam longint AMAX = (64'sd1 <<< 47) - 1;
  localparam longint AMIN = -(64'sd1 <<< 47);
  localparam longint DMAX = 64'sd2147483647;
  localparam longint DMIN = -64'sd2147483648;
  localparam longint S39  = 64'sd1 <<< 39;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  fog_rate_decimator_if #(.DATA_W(DATA_W), .ACC_W(48), .CNT_W(CNT_W)) bus   ();
  fog_rate_decimator_if #(.DATA_W(DATA_W), .ACC_W(40), .CNT_W(CNT_W)) bus40 ();

  fog_rate_decimator #(.DATA_W(DATA_W), .ACC_W(48), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  fog_rate_decimator #(.DATA_W(DATA_W), .ACC_W(40), .CNT_W(CNT_W)) dut40 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus40)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: steps of the open frame sit in a queue.
  bit     m_active;
  bit     m_pend;
  longint m_pend_sum;
  longint m_q[$];
  int     m_dec;
  longint m_sum;
  longint m_avg;
  bit     m_valid;
  bit     m_overrun;
  bit     m_sat;
  int     m_fcnt;

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint fold(input longint q[$], output bit clamped);
    longint s;
    s       = 0;
    clamped = 1'b0;
    foreach (q[i]) begin
      if (s + q[i] > AMAX || s + q[i] < AMIN) clamped = 1'b1;
      s = clamp(s + q[i], AMIN, AMAX);
    end
    return s;
  endfunction

  task automatic push_step(input longint step);
    longint s;
    bit     c;
    m_q.push_back(step);
    s = fold(m_q, c);
    if (c) m_sat = 1'b1;
    if (m_q.size() == m_dec) begin
      m_pend     = 1'b1;
      m_pend_sum = s;
    end
  endtask

  task automatic model_edge();
    int dnew;
    dnew = (bus.i_dec_cnt == 0) ? 1 : int'(bus.i_dec_cnt);
    if (bus.i_clr) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_sat     = 1'b0;
      m_fcnt    = 0;
      m_pend    = 1'b0;
      m_q.delete();
      m_active  = bus.i_en;
      m_dec     = dnew;
    end else if (m_pend) begin
      m_sum = m_pend_sum;
      m_avg = clamp(m_pend_sum >>> int'(bus.i_avg_shift), DMIN, DMAX);
      if (m_valid && !bus.i_rd_ack) m_overrun = 1'b1;
      m_valid  = 1'b1;
      m_fcnt   = (m_fcnt + 1) & 16'hFFFF;
      m_pend   = 1'b0;
      m_q.delete();
      m_dec    = dnew;
      m_active = bus.i_en;
      if (bus.i_en && bus.i_trig) push_step(longint'(bus.i_step));
    end else begin
      if (bus.i_rd_ack) m_valid = 1'b0;
      if (!m_active) begin
        if (bus.i_en) begin
          m_active = 1'b1;
          m_dec    = dnew;
        end
      end else if (!bus.i_en) begin
        m_active = 1'b0;
        m_q.delete();
      end else if (bus.i_trig) begin
        push_step(longint'(bus.i_step));
      end
    end
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("sum",       bus.o_sum,       m_sum);
    check("avg",       bus.o_avg,       m_avg);
    check("valid",     bus.o_valid,     m_valid);
    check("overrun",   bus.o_overrun,   m_overrun);
    check("sat",       bus.o_sat,       m_sat);
    check("frame_cnt", bus.o_frame_cnt, m_fcnt);
  endtask

  task automatic trig_step(input int step);
    bus.i_trig = 1'b1;
    bus.i_step = step;
    tick();
    bus.i_trig = 1'b0;
  endtask

  task automatic clear_with(input int dec, input int shift);
    bus.i_clr       = 1'b1;
    bus.i_dec_cnt   = 16'(dec);
    bus.i_avg_shift = 5'(shift);
    tick();
    bus.i_clr = 1'b0;
  endtask

  task automatic tick40();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.i_en        = 1'b0;
    bus.i_clr       = 1'b0;
    bus.i_trig      = 1'b0;
    bus.i_step      = '0;
    bus.i_dec_cnt   = '0;
    bus.i_avg_shift = '0;
    bus.i_rd_ack    = 1'b0;
    bus40.i_en        = 1'b0;
    bus40.i_clr       = 1'b0;
    bus40.i_trig      = 1'b0;
    bus40.i_step      = '0;
    bus40.i_dec_cnt   = '0;
    bus40.i_avg_shift = '0;
    bus40.i_rd_ack    = 1'b0;
    m_active = 1'b0; m_pend = 1'b0; m_pend_sum = 0; m_dec = 1;
    m_sum = 0; m_avg = 0; m_valid = 1'b0; m_overrun = 1'b0; m_sat = 1'b0; m_fcnt = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum",       bus.o_sum,       0);
    check("rst_avg",       bus.o_avg,       0);
    check("rst_valid",     bus.o_valid,     0);
    check("rst_overrun",   bus.o_overrun,   0);
    check("rst_sat",       bus.o_sat,       0);
    check("rst_frame_cnt", bus.o_frame_cnt, 0);
    rst_n = 1'b1;

    // Disabled block ignores triggers
    for (int i = 0; i < 10; i++) trig_step(100);
    tick();
    check("idle_valid", bus.o_valid, 0);
    check("idle_sum",   bus.o_sum,   0);

    // Basic frame: 10 - 3 + 7 + 2
    bus.i_en        = 1'b1;
    bus.i_dec_cnt   = 16'd4;
    bus.i_avg_shift = 5'd2;
    tick();
    trig_step(10); trig_step(-3); trig_step(7); trig_step(2);
    check("basic_early_valid", bus.o_valid, 0);
    tick();
    check("basic_sum",   bus.o_sum,       16);
    check("basic_avg",   bus.o_avg,       4);
    check("basic_valid", bus.o_valid,     1);
    check("basic_fcnt",  bus.o_frame_cnt, 1);
    bus.i_rd_ack = 1'b1; tick(); bus.i_rd_ack = 1'b0;
    check("ack_valid", bus.o_valid, 0);

    // Two unread frames overrun
    clear_with(2, 0);
    for (int i = 0; i < 4; i++) trig_step(5);
    tick();
    check("ovr_sum",     bus.o_sum,     10);
    check("ovr_overrun", bus.o_overrun, 1);

    // Ack coincident with the second latch prevents overrun
    clear_with(2, 0);
    trig_step(5); trig_step(5);
    tick();
    trig_step(5); trig_step(5);
    bus.i_rd_ack = 1'b1; tick(); bus.i_rd_ack = 1'b0;
    check("ackl_overrun", bus.o_overrun, 0);
    check("ackl_valid",   bus.o_valid,   1);
    check("ackl_sum",     bus.o_sum,     10);

    // One trigger per frame, triggers back to back; dec_cnt 1 and 0
    for (int d = 1; d >= 0; d--) begin
      clear_with(d, 0);
      trig_step(1);
      trig_step(2);
      check("b2b_sum1", bus.o_sum, 1);
      trig_step(3);
      check("b2b_sum2", bus.o_sum, 2);
      tick();
      check("b2b_sum3", bus.o_sum,       3);
      check("b2b_fcnt", bus.o_frame_cnt, 3);
      tick();
    end

    // o_avg clamps without setting o_sat
    clear_with(4, 0);
    for (int i = 0; i < 4; i++) trig_step(32'h7FFF_FFFF);
    tick();
    check("avgclamp_sum", bus.o_sum, 64'sd4 * 64'sd2147483647);
    check("avgclamp_avg", bus.o_avg, DMAX);
    check("avgclamp_sat", bus.o_sat, 0);

    // Mid-frame disable discards the partial frame
    clear_with(8, 0);
    for (int i = 0; i < 3; i++) trig_step(1);
    bus.i_en = 1'b0; tick();
    bus.i_en = 1'b1; tick();
    for (int i = 0; i < 8; i++) trig_step(1);
    tick();
    check("dis_sum",   bus.o_sum,   8);
    check("dis_valid", bus.o_valid, 1);
    bus.i_rd_ack = 1'b1; tick(); bus.i_rd_ack = 1'b0;

    // Clear coincident with the completing trigger
    for (int i = 0; i < 7; i++) trig_step(1);
    bus.i_clr = 1'b1;
    trig_step(1);
    bus.i_clr = 1'b0;
    tick(); tick();
    check("clr_valid",   bus.o_valid,     0);
    check("clr_overrun", bus.o_overrun,   0);
    check("clr_fcnt",    bus.o_frame_cnt, 0);
    check("clr_sum",     bus.o_sum,       8);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.i_en        = ($urandom_range(0, 99) < 95);
      bus.i_clr       = ($urandom_range(0, 99) < 2);
      bus.i_trig      = ($urandom_range(0, 99) < 60);
      bus.i_step      = $urandom;
      bus.i_dec_cnt   = 16'($urandom_range(0, 5));
      bus.i_avg_shift = 5'($urandom_range(0, 31));
      bus.i_rd_ack    = ($urandom_range(0, 99) < 30);
      tick();
    end
    bus.i_clr = 1'b0; bus.i_trig = 1'b0; bus.i_rd_ack = 1'b0;

    // Accumulator saturation in the 40-bit build
    bus40.i_en        = 1'b1;
    bus40.i_dec_cnt   = 16'd300;
    bus40.i_avg_shift = 5'd0;
    tick40();
    bus40.i_trig = 1'b1;
    bus40.i_step = 32'h7FFF_FFFF;
    repeat (100) tick40();
    check("sat40_pre", bus40.o_sat, 0);
    repeat (200) tick40();
    bus40.i_trig = 1'b0;
    tick40();
    check("sat40_sum",   bus40.o_sum,       S39 - 1);
    check("sat40_avg",   bus40.o_avg,       DMAX);
    check("sat40_flag",  bus40.o_sat,       1);
    check("sat40_valid", bus40.o_valid,     1);
    check("sat40_fcnt",  bus40.o_frame_cnt, 1);
    bus40.i_clr = 1'b1; tick40(); bus40.i_clr = 1'b0;
    check("sat40_clr", bus40.o_sat, 0);
    bus40.i_trig = 1'b1;
    bus40.i_step = 32'h8000_0000;
    repeat (300) tick40();
    bus40.i_trig = 1'b0;
    tick40();
    check("sat40_nsum", bus40.o_sum, -S39);
    check("sat40_navg", bus40.o_avg, DMIN);
    check("sat40_nsat", bus40.o_sat, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fog_rate_decimator.md
Name: fog_rate_decimator

Overview:
- Downstream consumer of the FOG loop's feedback-step output (o_step, qualified by the o_step_sync pulse).
- Integrates signed step values over a programmable number of step triggers (one frame).
- Latches each frame result into a double-buffered output register with a valid/ack handshake toward the CPU readout.
- Replaces ad-hoc moving-average filtering of the step before the CPU with a decimated, lossless angle-increment sum plus scaled average.

Parameters:
- DATA_W, 32, width of the signed step input and of o_avg
- ACC_W, 48, width of the signed accumulator and of o_sum
- CNT_W, 16, width of the decimation count and the frame counter

Ports:
- i_clk  in  1  system clock (CLOCK_DAC domain)
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  enable; low holds the block idle and clears the accumulator
- i_clr  in  1  synchronous clear of accumulator, counters and sticky flags
- i_trig  in  1  one-clock step-valid pulse (o_step_sync)
- i_step  in  DATA_W  signed step value, sampled when i_trig=1
- i_dec_cnt  in  CNT_W  triggers per frame; 0 is treated as 1
- i_avg_shift  in  5  arithmetic right shift applied to the sum to form o_avg
- i_rd_ack  in  1  one-clock CPU read acknowledge; clears o_valid
- o_sum  out  ACC_W  signed latched frame sum
- o_avg  out  DATA_W  signed (o_sum >>> i_avg_shift), saturated to DATA_W
- o_valid  out  1  new frame available
- o_overrun  out  1  sticky: a frame was latched while o_valid was still 1
- o_sat  out  1  sticky: accumulator saturated at least once
- o_frame_cnt  out  CNT_W  count of latched frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; accumulator 0; trigger counter 0; FSM in ST_IDLE.
- FSM states:
  - ST_IDLE: accumulator and trigger counter held at 0; ignores i_trig.
    - i_en=1 -> ST_ACC; i_dec_cnt is latched into dec_reg (0 -> 1) on this transition.
  - ST_ACC: on i_trig, acc <= sat(acc + sext(i_step)) and cnt <= cnt + 1.
    - When the trig that makes cnt == dec_reg arrives -> ST_DUMP; the final step is included in the sum.
  - ST_DUMP (exactly one cycle):
    - o_sum <= acc; o_avg <= sat_DATA_W(acc >>> i_avg_shift); o_valid <= 1; o_frame_cnt <= o_frame_cnt + 1.
    - acc <= 0, cnt <= 0; dec_reg re-latched from i_dec_cnt.
    - Return to ST_ACC, or to ST_IDLE if i_en=0.
  - i_en=0 in ST_ACC -> ST_IDLE next cycle; the partial frame is discarded and o_valid/o_sum are unchanged.
- Latency: o_valid rises on the clock edge after the cycle holding the frame-completing i_trig (1 cycle).
- i_trig in the ST_DUMP cycle: that step is accumulated as the first sample of the new frame (acc <= sext(i_step), cnt <= 1). No step is ever lost.
- Saturation:
  - The accumulator clamps at ±(2^(ACC_W-1)) bounds (max = 2^(ACC_W-1)-1, min = -2^(ACC_W-1)); o_sat set sticky on any clamp.
  - o_avg clamps to the DATA_W signed range. o_avg clamping does not set o_sat.
- Handshake:
  - i_rd_ack with o_valid=1 clears o_valid next cycle. i_rd_ack with o_valid=0 is ignored.
  - Latch while o_valid=1 and no ack in the same cycle: data is overwritten, o_valid stays 1, o_overrun set sticky.
  - Latch and i_rd_ack in the same cycle: new data latched, o_valid stays 1, no overrun.
- i_clr: next cycle acc=0, cnt=0, o_valid=0, o_overrun=0, o_sat=0, o_frame_cnt=0. o_sum/o_avg are retained. FSM goes to ST_ACC if i_en=1, else ST_IDLE, and dec_reg is re-latched.
  - i_clr has priority over a simultaneous frame completion; the completing frame is discarded.
- i_dec_cnt and i_avg_shift changes mid-frame do not affect dec_reg until the next frame boundary. i_avg_shift is applied at ST_DUMP only.
- o_frame_cnt wraps 0xFFFF -> 0x0000 with no flag.

Test Plan:
- Reset/idle: i_rst_n=0 then 1 with i_en=0, 10 trigs of i_step=100 -> all outputs 0, o_valid never rises.
- Basic frame: i_en=1, i_dec_cnt=4, i_avg_shift=2, trigs with steps 10, -3, 7, 2 -> one cycle after 4th trig o_sum=16, o_avg=4, o_valid=1, o_frame_cnt=1.
- Handshake/overrun: dec_cnt=2, steps all 5, no ack across two frames -> o_sum=10, o_overrun=1. Repeat with i_rd_ack coincident with the second latch -> o_overrun=0, o_valid=1.
- Boundary trig: dec_cnt=1 with i_trig every cycle, steps 1, 2, 3 -> three consecutive latches, o_sum = 1, 2, 3, o_frame_cnt=3, no missed step. Also i_dec_cnt=0 behaves identically to 1.
- Saturation: ACC_W=48, dec_cnt=65535, i_step=0x7FFFFFFF every trig -> o_sum = 2^47-1? no: sum = 65535*(2^31-1) < 2^47 so o_sat=0, and o_avg with shift 0 clamps to 0x7FFFFFFF. Force via step pattern beyond 2^47 (dec_cnt=65535, 2 frames concatenated not allowed) -> use ACC_W=40 build: o_sum=2^39-1, o_sat=1.
- Mid-frame disable/clear: dec_cnt=8, 3 trigs, drop i_en for 1 cycle, re-enable, 8 trigs of 1 -> o_sum=8. Assert i_clr simultaneous with 8th trig -> no latch, o_valid=0, flags cleared.
